// File: rtl/fixed_activation_arbiter.sv
// fixed_activation_arbiter
// Shares one activation datapath between NUM_REQ requester streams. Grants are
// round-robin and held for BURST_LEN beats. Every issued beat leaves its channel
// number in a tag FIFO, and in-order results are steered back using that tag.
// Optional feature macro: ACT_ARB_PERF_EN adds perf_beats / perf_stall counters.
module fixed_activation_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PARALLELISM  = 1,
  parameter int BURST_LEN    = 10,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0]        act_data_out,
  output logic                                     act_valid_out,
  input  logic                                     act_ready_in,
  input  logic [PARALLELISM*DATA_WIDTH-1:0]        act_data_in,
  input  logic                                     act_valid_in,
  output logic                                     act_ready_out,
  output logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  input  logic [NUM_REQ-1:0]                       rsp_ready,
  output logic                                     busy
`ifdef ACT_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]                    perf_beats,
  output logic [15:0]                              perf_stall
`endif
);

  localparam int BEAT_W     = PARALLELISM * DATA_WIDTH;
  localparam int CH_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W      = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W      = $clog2(MAX_INFLIGHT + 1);
  localparam int BEAT_CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_REQ - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         rr_ptr, owner, pick_idx, next_owner;
  logic                    pick_found;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic                    run_q;

  logic [CH_W-1:0]         tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        tag_count;
  logic [CH_W-1:0]         head;
  logic                    fifo_empty, issue_ok, push, pop, last_beat;

  assign fifo_empty = (tag_count == '0);
  assign issue_ok   = (tag_count < MAX_CNT);
  assign head       = tag_mem[rd_ptr];
  assign push       = act_valid_out && act_ready_in;
  assign pop        = act_valid_in && act_ready_out && !fifo_empty;
  assign last_beat  = push && (beat_cnt == BEAT_LAST);
  assign next_owner = (owner == CH_LAST) ? '0 : owner + CH_W'(1);

  // Round-robin search: first asserted valid starting at rr_ptr, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: one arbitration cycle in IDLE, then hold the grant for a full burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (last_beat)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue-side outputs; gating uses only the registered tag count so rsp_ready never reaches act_ready_in.
  always_comb begin
    act_valid_out = 1'b0;
    req_ready     = '0;
    act_data_out  = '0;
    if (state_q == GRANT) begin
      act_valid_out    = req_valid[owner] && issue_ok;
      req_ready[owner] = act_ready_in && issue_ok;
      act_data_out     = req_data[owner*BEAT_W +: BEAT_W];
    end
  end

  // Owner, round-robin pointer and beat counter bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (pick_found) begin
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
    end else if (push) begin
      if (last_beat) begin
        rr_ptr   <= next_owner;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      end
    end
  end

  // Goes high one clock after reset release; keeps the return-side ready at 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Tag storage: the channel number of every issued beat.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

  // Return steering: only the head tag's channel sees valid; unmatched results are sunk.
  always_comb begin
    rsp_valid     = '0;
    act_ready_out = 1'b0;
    rsp_data      = '0;
    if (run_q) begin
      rsp_data      = {NUM_REQ{act_data_in}};
      act_ready_out = fifo_empty ? 1'b1 : rsp_ready[head];
      if (!fifo_empty) rsp_valid[head] = act_valid_in;
    end
  end

  assign busy = (state_q != IDLE) || !fifo_empty;

`ifdef ACT_ARB_PERF_EN
  logic [15:0] beats_q [NUM_REQ];
  logic [15:0] stall_q;

  // Saturating per-channel issued-beat counters and GRANT stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_REQ; c++) beats_q[c] <= '0;
      stall_q <= '0;
    end else begin
      if (push && beats_q[owner] != 16'hFFFF) beats_q[owner] <= beats_q[owner] + 16'd1;
      if (state_q == GRANT && req_valid[owner] && !push && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  // Flatten the per-channel counters onto the output bus.
  always_comb begin
    perf_beats = '0;
    for (int c = 0; c < NUM_REQ; c++) perf_beats[c*16 +: 16] = beats_q[c];
  end

  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_fixed_activation_arbiter.sv
// tb_fixed_activation_arbiter
// Directed bench for fixed_activation_arbiter at default parameters
// (4 channels, 8-bit single lane, 10-beat bursts, 4 tags in flight).
module tb_fixed_activation_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int BURST   = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [DW-1:0]        act_data_out;
  logic                 act_valid_out;
  logic                 act_ready_in;
  logic [DW-1:0]        act_data_in;
  logic                 act_valid_in;
  logic                 act_ready_out;
  logic [NUM_REQ*DW-1:0] rsp_data;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic                 busy;
`ifdef ACT_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] perf_beats;
  logic [15:0]           perf_stall;
`endif

  int test_count = 0;
  int fail_count = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  fixed_activation_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .PARALLELISM(1),
    .BURST_LEN(BURST), .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .act_data_out(act_data_out), .act_valid_out(act_valid_out), .act_ready_in(act_ready_in),
    .act_data_in(act_data_in), .act_valid_in(act_valid_in), .act_ready_out(act_ready_out),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .busy(busy)
`ifdef ACT_ARB_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  // 10 ns clock; inputs change and outputs are sampled around the falling edge.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*DW-1:0] data,
                               input logic rvalid, input logic [DW-1:0] rdata,
                               input logic [NUM_REQ-1:0] rready);
    req_valid    = valid;
    req_data     = data;
    act_valid_in = rvalid;
    act_data_in  = rdata;
    rsp_ready    = rready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst          = 1'b0;
    act_ready_in = 1'b0;
    applyStimulus('0, '0, 1'b0, '0, '0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_act_valid", 64'(act_valid_out), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_act_ready_out", 64'(act_ready_out), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unmatched return with an empty tag FIFO is sunk silently.
    @(negedge clk);
    applyStimulus('0, '0, 1'b1, 8'h55, '0);
    #1;
    checkOutput("unmatched_ready", 64'(act_ready_out), 64'd1);
    checkOutput("unmatched_rsp_valid", 64'(rsp_valid), 64'd0);

    // Single channel 2, no returns at first: four beats fill the tag FIFO.
    @(negedge clk);
    act_ready_in = 1'b1;
    applyStimulus(4'b0100, 32'h0001_0000, 1'b0, '0, 4'hF);
    #1;
    checkOutput("arb_cycle_valid", 64'(act_valid_out), 64'd0);
    checkOutput("arb_cycle_busy", 64'(busy), 64'd0);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      req_data = 32'(b) << 16;
      #1;
      checkOutput("issue_valid", 64'(act_valid_out), 64'd1);
      checkOutput("issue_data", 64'(act_data_out), 64'(b));
      checkOutput("issue_ready", 64'(req_ready), 64'b0100);
    end

    // Full: no issue even though a return is popped this very cycle.
    @(negedge clk);
    req_data     = 32'h0005_0000;
    act_valid_in = 1'b1;
    act_data_in  = 8'h02;
    #1;
    checkOutput("full_valid", 64'(act_valid_out), 64'd0);
    checkOutput("full_ready", 64'(req_ready), 64'd0);
    checkOutput("ret_rsp_valid", 64'(rsp_valid), 64'b0100);
    checkOutput("ret_ready", 64'(act_ready_out), 64'd1);
    checkOutput("ret_data", 64'(rsp_data), 64'h0202_0202);
    checkOutput("full_busy", 64'(busy), 64'd1);

    // Issue resumes the next cycle; channel 2 stalls its return.
    @(negedge clk);
    act_data_in = 8'h03;
    rsp_ready   = 4'b1011;
    #1;
    checkOutput("reissue_valid", 64'(act_valid_out), 64'd1);
    checkOutput("reissue_data", 64'(act_data_out), 64'd5);
    checkOutput("stall_ready", 64'(act_ready_out), 64'd0);
    checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_data = 32'h0006_0000;
      #1;
      checkOutput("stall_ready_hold", 64'(act_ready_out), 64'd0);
      checkOutput("stall_full", 64'(act_valid_out), 64'd0);
      checkOutput("stall_data", 64'(rsp_data), 64'h0303_0303);
      checkOutput("stall_rsp_hold", 64'(rsp_valid), 64'b0100);
    end
    @(negedge clk);
    rsp_ready = 4'hF;
    #1;
    checkOutput("release_ready", 64'(act_ready_out), 64'd1);
    checkOutput("release_full", 64'(act_valid_out), 64'd0);

    // Issue and return flow together for beats 6..10 / results 0x04..0x08.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_data    = 32'(6 + k) << 16;
      act_data_in = 8'(4 + k);
      #1;
      checkOutput("flow_valid", 64'(act_valid_out), 64'd1);
      checkOutput("flow_data", 64'(act_data_out), 64'(6 + k));
      checkOutput("flow_rsp_valid", 64'(rsp_valid), 64'b0100);
      checkOutput("flow_rsp_data", 64'(rsp_data), 64'({4{8'(4 + k)}}));
    end

    // Burst done; drain results 0x09..0x0B.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = '0;
      act_data_in = 8'(9 + k);
      #1;
      checkOutput("tail_rsp_valid", 64'(rsp_valid), 64'b0100);
      checkOutput("tail_rsp_data", 64'(rsp_data), 64'({4{8'(9 + k)}}));
      checkOutput("tail_idle", 64'(act_valid_out), 64'd0);
      checkOutput("tail_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    act_valid_in = 1'b0;
    #1;
    checkOutput("drained_busy", 64'(busy), 64'd0);
    checkOutput("drained_rsp_valid", 64'(rsp_valid), 64'd0);

    // Channel 0 granted (pointer now at 3, wraps to 0); results always returned so tags never fill.
    @(negedge clk);
    applyStimulus(4'b0001, 32'hD3D2_D1D0, 1'b1, 8'h00, 4'hF);
    #1;
    checkOutput("mid_arb_valid", 64'(act_valid_out), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      #1;
      checkOutput("mid_issue_ready", 64'(req_ready), 64'b0001);
      checkOutput("mid_issue_data", 64'(act_data_out), 64'hD0);
    end

    // Reset after beat 4: everything drops at once.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_act_valid", 64'(act_valid_out), 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_act_ready_out", 64'(act_ready_out), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_act_data", 64'(act_data_out), 64'd0);
    checkOutput("midrst_rsp_data", 64'(rsp_data), 64'd0);

    // Release with ch0 and ch1 valid: ch0 wins, then fair rotation 0,1,2,3,0.
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b0011;
    #1;
    checkOutput("post_rst_idle", 64'(req_ready), 64'd0);
    for (int bi = 0; bi < 5; bi++) begin
      for (int b = 0; b < BURST; b++) begin
        @(negedge clk);
        #1;
        checkOutput("burst_ready", 64'(req_ready), 64'(4'b0001 << order[bi]));
        checkOutput("burst_data", 64'(act_data_out), 64'(8'hD0 + 8'(order[bi])));
      end
      @(negedge clk);
      if (bi == 0) req_valid = 4'hF;
      if (bi == 4) req_valid = '0;
      #1;
      checkOutput("gap_ready", 64'(req_ready), 64'd0);
      checkOutput("gap_valid", 64'(act_valid_out), 64'd0);
    end
    @(negedge clk);
    act_valid_in = 1'b0;
    #1;
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
